// File: rtl/run_launcher_if.sv
// Host-side bundle of the run_launcher handshake: host controls plus the
// control-unit completion flag in, status/timing results out.
interface run_launcher_if #(
  parameter int CNT_W = 24
);
  logic             start_req;
  logic             clear;
  logic             end_process;
  logic [1:0]       status;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start_req, clear, end_process,
    input  status, busy, done, timed_out, cycle_count
  );

  modport slave (
    input  start_req, clear, end_process,
    output status, busy, done, timed_out, cycle_count
  );
endinterface

// File: rtl/run_launcher.sv
// Launches a control-unit run via status=01, times it in cycles and reports
// completion (end_process) or a timeout after MAX_CYCLES.
module run_launcher #(
  parameter int               CNT_W       = 24,
  parameter logic [CNT_W-1:0] MAX_CYCLES  = 24'hFF_FFFF,
  parameter int               HOLD_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  run_launcher_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_stop;

  // The counter never passes MAX_CYCLES, so a completion seen in the same
  // cycle as the limit reports exactly MAX_CYCLES; all-ones is the hard stop.
  assign cnt_stop = (cnt_q == MAX_CYCLES) || (&cnt_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        // A sticky end_process means the processor still sits in endop.
        if (bus.start_req && !bus.end_process) begin
          state_d = S_LAUNCH;
          hold_d  = '0;
          cnt_d   = '0;
        end
      end
      S_LAUNCH: begin
        hold_d = hold_q + 4'd1;
        if (!cnt_stop) cnt_d = cnt_q + 1'b1;
        if (hold_q == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!cnt_stop) cnt_d = cnt_q + 1'b1;
        if (bus.end_process)            state_d = S_DONE;
        else if (cnt_q == MAX_CYCLES)   state_d = S_TIMEOUT;
      end
      S_DONE, S_TIMEOUT: begin
        if (bus.clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.status    = 2'b00;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.timed_out = 1'b0;
    unique case (state_q)
      S_LAUNCH: begin
        bus.status = 2'b01;
        bus.busy   = 1'b1;
      end
      S_RUN:     bus.busy = 1'b1;
      S_DONE: begin
        bus.status = 2'b10;
        bus.done   = 1'b1;
      end
      S_TIMEOUT: begin
        bus.status    = 2'b11;
        bus.timed_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cycle_count = cnt_q;

endmodule
